// File: rtl/dmem_sched.sv
// Dual-lane data-memory scheduler: serializes two memory-stage slots onto one
// memory port in program order and stalls execute-to-memory until both finish.
module dmem_sched #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [1:0]              lane_valid,
    input  logic [1:0]              lane_we,
    input  logic [2*ADDR_W-1:0]     lane_addr,
    input  logic [2*DATA_W-1:0]     lane_wdata,
    input  logic [2*DATA_W/8-1:0]   lane_be,
    output logic                    mem_stall,
    output logic [1:0]              lane_done,
    output logic [2*DATA_W-1:0]     lane_rdata,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [ADDR_W-1:0]       dmem_addr,
    output logic [DATA_W-1:0]       dmem_wdata,
    output logic [DATA_W/8-1:0]     dmem_be,
    input  logic                    dmem_gnt,
    input  logic                    dmem_rvalid,
    input  logic [DATA_W-1:0]       dmem_rdata
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
        REQ1,
        WAIT1,
        DONE,
        DRAIN
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             valid_q;
    logic [1:0]             we_q;
    logic [2*ADDR_W-1:0]    addr_q;
    logic [2*DATA_W-1:0]    wdata_q;
    logic [2*BE_W-1:0]      be_q;
    logic [2*DATA_W-1:0]    rdata_q;
    logic [1:0]             done_q, done_d;
    logic                   start;

    // A new group is accepted only from IDLE and only when not being flushed.
    assign start = (state_q == IDLE) && (|lane_valid) && !flush;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every variable in a combinational block gets a default first so
    // that no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = lane_valid[0] ? REQ0 : REQ1;
            end
            REQ0, REQ1: begin
                if (dmem_gnt) begin
                    if (flush)                 state_d = DRAIN;
                    else if (state_q == REQ0)  state_d = WAIT0;
                    else                       state_d = WAIT1;
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            WAIT0: begin
                if (dmem_rvalid) begin
                    if (flush)           state_d = IDLE;
                    else if (valid_q[1]) state_d = REQ1;
                    else                 state_d = DONE;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            WAIT1: begin
                if (dmem_rvalid)  state_d = flush ? IDLE : DONE;
                else if (flush)   state_d = DRAIN;
            end
            DONE:    state_d = IDLE;
            DRAIN: begin
                if (dmem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_stall  = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = we_q[0];
        dmem_addr  = addr_q[ADDR_W-1:0];
        dmem_wdata = wdata_q[DATA_W-1:0];
        dmem_be    = be_q[BE_W-1:0];
        unique case (state_q)
            IDLE:                      mem_stall = (|lane_valid) && !flush;
            REQ0:                      begin mem_stall = 1'b1; dmem_req = 1'b1; end
            REQ1: begin
                mem_stall  = 1'b1;
                dmem_req   = 1'b1;
                dmem_we    = we_q[1];
                dmem_addr  = addr_q[ADDR_W +: ADDR_W];
                dmem_wdata = wdata_q[DATA_W +: DATA_W];
                dmem_be    = be_q[BE_W +: BE_W];
            end
            WAIT0, WAIT1, DRAIN:       mem_stall = 1'b1;
            default:                   mem_stall = 1'b0;
        endcase
        // The IDLE term depends on live inputs, so reset must mask it directly.
        if (!rst) mem_stall = 1'b0;
    end

    assign done_d = (state_d == DONE) ? valid_q : 2'b00;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            we_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            done_q  <= '0;
        end else begin
            done_q <= done_d;
            if (start) begin
                valid_q <= lane_valid;
                we_q    <= lane_we;
                addr_q  <= lane_addr;
                wdata_q <= lane_wdata;
                be_q    <= lane_be;
                rdata_q <= '0;
            end else if (dmem_rvalid && !flush) begin
                if (state_q == WAIT0 && !we_q[0]) rdata_q[DATA_W-1:0]      <= dmem_rdata;
                if (state_q == WAIT1 && !we_q[1]) rdata_q[DATA_W +: DATA_W] <= dmem_rdata;
            end
        end
    end

    // A flush arriving in DONE cancels the completion pulse of that same cycle.
    assign lane_done  = done_q & {2{!flush}};
    assign lane_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_sched.sv
// Directed self-checking bench for dmem_sched: latency, ordering, gnt stalls,
// flush/drain handling and asynchronous reset.
module tb_dmem_sched;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic [1:0]     lane_valid;
    logic [1:0]     lane_we;
    logic [63:0]    lane_addr;
    logic [63:0]    lane_wdata;
    logic [7:0]     lane_be;
    logic           mem_stall;
    logic [1:0]     lane_done;
    logic [63:0]    lane_rdata;
    logic           dmem_req;
    logic           dmem_we;
    logic [31:0]    dmem_addr;
    logic [31:0]    dmem_wdata;
    logic [3:0]     dmem_be;
    logic           dmem_gnt;
    logic           dmem_rvalid;
    logic [31:0]    dmem_rdata;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int proto_err = 0;
    int outstanding;
    int occ;

    dmem_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .lane_valid  (lane_valid),
        .lane_we     (lane_we),
        .lane_addr   (lane_addr),
        .lane_wdata  (lane_wdata),
        .lane_be     (lane_be),
        .mem_stall   (mem_stall),
        .lane_done   (lane_done),
        .lane_rdata  (lane_rdata),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_be     (dmem_be),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata)
    );

    always #5 clk = ~clk;

    // Memory-side protocol monitor: a response needs an accepted request.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= 0;
        end else begin
            if (dmem_rvalid && outstanding == 0) proto_err <= proto_err + 1;
            outstanding <= outstanding + int'(dmem_req && dmem_gnt) - int'(dmem_rvalid);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        flush       = 1'b0;
        lane_valid  = 2'b00;
        lane_we     = 2'b00;
        lane_addr   = '0;
        lane_wdata  = '0;
        lane_be     = '0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        clear_inputs();
        sample();
        check("rst_stall", 64'(mem_stall), 64'd0);
        check("rst_req",   64'(dmem_req),  64'd0);
        check("rst_done",  64'(lane_done), 64'd0);
        check("rst_rdata", lane_rdata,     64'd0);
        check("rst_addr",  64'(dmem_addr), 64'd0);
        tick();
        rst = 1'b1;
        tick();

        // Flush in IDLE: no stall, no request.
        lane_valid = 2'b01; flush = 1'b1;
        sample();
        check("idle_flush_stall", 64'(mem_stall), 64'd0);
        tick();
        clear_inputs();
        sample();
        check("idle_flush_req", 64'(dmem_req), 64'd0);
        tick();

        // Lane 0 load only.
        lane_valid = 2'b01; lane_addr[31:0] = 32'h100; lane_be[3:0] = 4'hF;
        sample();
        check("t1_t0_stall", 64'(mem_stall), 64'd1);
        check("t1_t0_req",   64'(dmem_req),  64'd0);
        tick();
        dmem_gnt = 1'b1;
        sample();
        check("t1_t1_req",   64'(dmem_req),  64'd1);
        check("t1_t1_addr",  64'(dmem_addr), 64'h100);
        check("t1_t1_we",    64'(dmem_we),   64'd0);
        check("t1_t1_stall", 64'(mem_stall), 64'd1);
        tick();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
        sample();
        check("t1_t2_req",   64'(dmem_req),  64'd0);
        check("t1_t2_stall", 64'(mem_stall), 64'd1);
        check("t1_t2_done",  64'(lane_done), 64'd0);
        tick();
        clear_inputs();
        sample();
        check("t1_t3_done",  64'(lane_done), 64'b01);
        check("t1_t3_rdata", lane_rdata,     64'h0000_0000_DEAD_BEEF);
        check("t1_t3_stall", 64'(mem_stall), 64'd0);
        tick();
        sample();
        check("t1_t4_done",  64'(lane_done), 64'd0);
        tick();

        // Both lanes: store then load.
        lane_valid = 2'b11; lane_we = 2'b01;
        lane_addr  = {32'h204, 32'h200};
        lane_wdata = {32'h0, 32'h11223344};
        lane_be    = 8'hFF;
        sample();
        check("t2_t0_stall", 64'(mem_stall), 64'd1);
        tick();
        dmem_gnt = 1'b1;
        sample();
        check("t2_t1_req",   64'(dmem_req),   64'd1);
        check("t2_t1_we",    64'(dmem_we),    64'd1);
        check("t2_t1_addr",  64'(dmem_addr),  64'h200);
        check("t2_t1_wdata", 64'(dmem_wdata), 64'h11223344);
        check("t2_t1_be",    64'(dmem_be),    64'hF);
        tick();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h55555555;
        sample();
        check("t2_t2_req", 64'(dmem_req), 64'd0);
        tick();
        dmem_rvalid = 1'b0; dmem_gnt = 1'b1;
        sample();
        check("t2_t3_req",  64'(dmem_req),  64'd1);
        check("t2_t3_we",   64'(dmem_we),   64'd0);
        check("t2_t3_addr", 64'(dmem_addr), 64'h204);
        tick();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
        sample();
        check("t2_t4_done",  64'(lane_done), 64'd0);
        check("t2_t4_stall", 64'(mem_stall), 64'd1);
        tick();
        clear_inputs();
        sample();
        check("t2_t5_done",  64'(lane_done), 64'b11);
        check("t2_t5_rdata", lane_rdata,     64'hCAFE_F00D_0000_0000);
        tick();

        // Lane 1 only, gnt withheld 3 cycles; latched fields must not track inputs.
        occ = 0;
        lane_valid = 2'b10; lane_addr = {32'h300, 32'h0}; lane_be = 8'h30;
        sample();
        if (mem_stall) occ++;
        tick();
        for (int i = 0; i < 4; i++) begin
            lane_addr = {32'hFFFF_0000 + 32'(i), 32'h0};
            lane_be   = 8'hF0;
            dmem_gnt  = (i == 3);
            sample();
            if (mem_stall) occ++;
            check($sformatf("t3_req_c%0d", i),  64'(dmem_req),  64'd1);
            check($sformatf("t3_addr_c%0d", i), 64'(dmem_addr), 64'h300);
            check($sformatf("t3_be_c%0d", i),   64'(dmem_be),   64'h3);
            tick();
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0BADC0DE;
        sample();
        if (mem_stall) occ++;
        check("t3_wait_req", 64'(dmem_req), 64'd0);
        tick();
        clear_inputs();
        sample();
        if (mem_stall) occ++;
        check("t3_done",  64'(lane_done), 64'b10);
        check("t3_rdata", lane_rdata,     64'h0BAD_C0DE_0000_0000);
        check("t3_occ",   64'(occ),       64'd6);
        tick();

        // Flush in WAIT0, response two cycles later.
        lane_valid = 2'b11; lane_addr = {32'h404, 32'h400}; lane_be = 8'hFF;
        tick();
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0; flush = 1'b1;
        sample();
        check("t4_flush_stall", 64'(mem_stall), 64'd1);
        tick();
        flush = 1'b0; lane_valid = 2'b00;
        sample();
        check("t4_drain_stall", 64'(mem_stall), 64'd1);
        check("t4_drain_req",   64'(dmem_req),  64'd0);
        tick();
        dmem_rvalid = 1'b1; dmem_rdata = 32'h44444444;
        sample();
        check("t4_drain2_stall", 64'(mem_stall), 64'd1);
        check("t4_drain2_req",   64'(dmem_req),  64'd0);
        tick();
        clear_inputs();
        sample();
        check("t4_idle_stall", 64'(mem_stall), 64'd0);
        check("t4_idle_req",   64'(dmem_req),  64'd0);
        check("t4_idle_done",  64'(lane_done), 64'd0);
        tick();
        sample();
        check("t4_after_done", 64'(lane_done), 64'd0);
        check("t4_after_req",  64'(dmem_req),  64'd0);
        tick();

        // Flush in REQ1 coinciding with gnt.
        lane_valid = 2'b11; lane_addr = {32'h504, 32'h500}; lane_be = 8'hFF;
        tick();
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
        tick();
        dmem_rvalid = 1'b0; dmem_gnt = 1'b1; flush = 1'b1;
        sample();
        check("t5_req1_req",  64'(dmem_req),  64'd1);
        check("t5_req1_addr", 64'(dmem_addr), 64'h504);
        tick();
        clear_inputs();
        sample();
        check("t5_drain_stall", 64'(mem_stall), 64'd1);
        check("t5_drain_req",   64'(dmem_req),  64'd0);
        tick();
        dmem_rvalid = 1'b1; dmem_rdata = 32'h99999999;
        sample();
        check("t5_drain2_done", 64'(lane_done), 64'd0);
        tick();
        clear_inputs();
        sample();
        check("t5_idle_stall", 64'(mem_stall), 64'd0);
        check("t5_idle_done",  64'(lane_done), 64'd0);
        tick();
        sample();
        check("t5_after_done", 64'(lane_done), 64'd0);
        tick();

        // Asynchronous reset during WAIT1, then a fresh single-lane load.
        lane_valid = 2'b11; lane_addr = {32'h604, 32'h600}; lane_be = 8'hFF;
        tick();
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hAAAA0000;
        tick();
        dmem_rvalid = 1'b0; dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_stall", 64'(mem_stall),  64'd0);
        check("t6_rst_req",   64'(dmem_req),   64'd0);
        check("t6_rst_done",  64'(lane_done),  64'd0);
        check("t6_rst_rdata", lane_rdata,      64'd0);
        check("t6_rst_addr",  64'(dmem_addr),  64'd0);
        tick();
        clear_inputs();
        rst = 1'b1;
        lane_valid = 2'b01; lane_addr = {32'h0, 32'h700}; lane_be = 8'h0F;
        sample();
        check("t6_new_t0_stall", 64'(mem_stall), 64'd1);
        tick();
        dmem_gnt = 1'b1;
        sample();
        check("t6_new_t1_req",  64'(dmem_req),  64'd1);
        check("t6_new_t1_addr", 64'(dmem_addr), 64'h700);
        tick();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h77777777;
        sample();
        check("t6_new_t2_done", 64'(lane_done), 64'd0);
        tick();
        clear_inputs();
        sample();
        check("t6_new_t3_done",  64'(lane_done), 64'b01);
        check("t6_new_t3_rdata", lane_rdata,     64'h0000_0000_7777_7777);
        tick();

        check("protocol_errors", 64'(proto_err), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dmem_sched.md
# dmem_sched

Dual-lane data-memory scheduler for the memory stage of the dual-issue pipeline. The two memory-stage slots can each carry a load or store. The core has a single data-memory port, so this block serializes the slot requests in program order (lane 0 before lane 1). It also stalls the execute-to-memory boundary until both slots have completed, then presents per-lane read data and completion pulses to the memory stage for forwarding to commit.

## Interface
Parameters
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte-enable width = DATA_W/8)

Ports
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-low
- flush  in  1  pipeline flush; cancels memory-stage slots
- lane_valid  in  2  slot i holds a memory op
- lane_we  in  2  slot i is a store
- lane_addr  in  2*ADDR_W  slot i address at [i*ADDR_W +: ADDR_W]
- lane_wdata  in  2*DATA_W  slot i store data
- lane_be  in  2*DATA_W/8  slot i byte enables
- mem_stall  out  1  hold the execute-to-memory register and everything upstream
- lane_done  out  2  one-cycle completion pulse per served slot
- lane_rdata  out  2*DATA_W  slot i load data, valid while lane_done[i]
- dmem_req  out  1  port request, held until dmem_gnt
- dmem_we, dmem_addr, dmem_wdata, dmem_be  out  1/ADDR_W/DATA_W/DATA_W/8  request fields
- dmem_gnt  in  1  request accepted this cycle (dmem_req && dmem_gnt)
- dmem_rvalid  in  1  one response per accepted request, loads and stores
- dmem_rdata  in  DATA_W  load data, valid with dmem_rvalid

## Operation
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE, DRAIN.
- IDLE:
  - On entry to a new group, latch lane_valid, lane_we, lane_addr, lane_wdata and lane_be, and clear the lane_rdata registers.
  - Go to REQ0 if lane_valid[0]; otherwise go to REQ1 if lane_valid[1].
  - If no lane is valid, stay in IDLE.
- REQn:
  - dmem_req=1, with fields driven from lane n's latched copy.
  - Stay in REQn until dmem_gnt, then go to WAITn.
- WAITn:
  - dmem_req=0.
  - On dmem_rvalid, if lane n is a load, capture dmem_rdata into lane n's rdata register.
  - Then WAIT0 goes to REQ1 if latched lane 1 is valid, else to DONE; WAIT1 goes to DONE.
- DONE:
  - mem_stall=0.
  - lane_done equals the latched lane_valid bits; lane_rdata is held.
  - Go to IDLE next cycle.
- Store lanes report lane_rdata=0.
- mem_stall:
  - Equals 1 in IDLE when |lane_valid && !flush.
  - Equals 1 in REQ*, WAIT* and DRAIN.
  - Equals 0 in DONE and in IDLE with no valid lane.
  - Forced to 0 while rst is low.
- Flush:
  - In IDLE: no action, mem_stall=0.
  - In REQn without dmem_gnt: go to IDLE next cycle and drop dmem_req.
  - In REQn with dmem_gnt in the same cycle: go to DRAIN.
  - In WAITn without dmem_rvalid: go to DRAIN.
  - In WAITn with dmem_rvalid in the same cycle: go to IDLE.
  - In DONE: suppress lane_done, go to IDLE.
- DRAIN:
  - dmem_req=0, mem_stall=1.
  - On dmem_rvalid, go to IDLE; the response is discarded and lane_done is never pulsed.
- At most one outstanding request. A dmem_rvalid outside WAIT/DRAIN is a protocol error and is ignored; the bench asserts it never occurs.

## Timing
- Reset values: state=IDLE, dmem_req=0, lane_done=0, lane_rdata=0, latched fields=0, mem_stall=0.
- Reset mid-transaction aborts immediately. The memory side is reset together with this block.
- Latency, single lane with gnt in its first REQ cycle and rvalid one cycle later:
  - t0 IDLE, t1 REQ0, t2 WAIT0, t3 DONE.
  - mem_stall is high t0–t2; lane_done pulses t3.
- Latency, both lanes with the same memory timing:
  - t0 IDLE, t1 REQ0, t2 WAIT0, t3 REQ1, t4 WAIT1, t5 DONE.
- Each gnt wait-state or rvalid wait-state adds exactly one cycle.
- dmem_* request fields are stable from the first REQn cycle through acceptance.
- lane_rdata and lane_done are registered outputs. mem_stall is combinational from state, lane_valid and flush.
- dmem_rvalid never arrives in the acceptance cycle; the earliest is the cycle after.

## Test plan
- Lane 0 load only, addr 0x100, gnt immediate, rvalid+1 with rdata 0xDEADBEEF -> dmem_req high at t1 only; lane_done=2'b01 and lane_rdata[0]=0xDEADBEEF at t3; mem_stall high t0–t2.
- Both lanes valid: lane 0 store to 0x200 with wdata 0x11223344 and be 0xF, lane 1 load from 0x204 returning 0xCAFEF00D -> store issued before load; lane_done=2'b11 at t5; lane_rdata[0]=0; lane_rdata[1]=0xCAFEF00D.
- Only lane 1 valid, gnt withheld 3 cycles -> dmem_req held for 4 cycles with fields stable; lane_done=2'b10 after rvalid; total occupancy 6 cycles.
- flush in WAIT0 with rvalid 2 cycles later -> state goes to DRAIN; mem_stall stays high until rvalid; lane_done never asserts; lane 1 is never requested; returns to IDLE.
- flush in REQ1 coinciding with dmem_gnt -> state goes to DRAIN; the next rvalid is discarded; no lane_done pulse.
- rst asserted low during WAIT1 -> all outputs go to zero asynchronously; after release, a new single-lane load completes with normal latency.
